// File: rtl/tensor_issue_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tensor_issue_arbiter: round-robin issue of lane requests onto the tensor |
// | core, with an in-order lane tag FIFO steering commit streams back.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tensor_issue_arbiter #(
  parameter int NUM_REQS  = 4,
  parameter int DATA_W    = 64,
  parameter int CDATA_W   = 64,
  parameter int MAX_OUTST = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              req_valid,
  input  logic [NUM_REQS*DATA_W-1:0]       req_data,
  output logic [NUM_REQS-1:0]              req_ready,
  output logic                             disp_valid,
  output logic [DATA_W-1:0]                disp_data,
  input  logic                             disp_ready,
  input  logic                             cmt_in_valid,
  input  logic [CDATA_W-1:0]               cmt_in_data,
  input  logic                             cmt_in_eop,
  output logic                             cmt_in_ready,
  output logic [NUM_REQS-1:0]              cmt_out_valid,
  output logic [CDATA_W-1:0]               cmt_out_data,
  output logic                             cmt_out_eop,
  input  logic [NUM_REQS-1:0]              cmt_out_ready,
  output logic [$clog2(MAX_OUTST+1)-1:0]   outst_cnt,
  output logic                             orphan_err
);

  localparam int c_LANE_W = $clog2(NUM_REQS);
  localparam int c_PTR_W  = $clog2(MAX_OUTST);
  localparam int c_CNT_W  = $clog2(MAX_OUTST+1);

  logic                r_disp_valid;
  logic [DATA_W-1:0]   r_disp_data;
  logic [c_LANE_W-1:0] r_rr_ptr;
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_orphan_err;
  logic [c_LANE_W-1:0] r_fifo [MAX_OUTST];

  logic [DATA_W-1:0]   w_req_data [NUM_REQS];
  logic [c_LANE_W-1:0] w_scan;
  logic [c_LANE_W-1:0] w_grant_idx;
  logic                w_grant_hit;
  logic                w_can_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_nonempty;
  logic [c_LANE_W-1:0] w_head;
  logic [c_LANE_W-1:0] w_rr_next;

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_unpack
    assign w_req_data[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Scan from rr_ptr, wrapping; first valid lane wins.
  always_comb begin
    w_grant_hit = 1'b0;
    w_grant_idx = '0;
    w_scan      = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      w_scan = c_LANE_W'((int'(r_rr_ptr) + k) % NUM_REQS);
      if (!w_grant_hit && req_valid[w_scan]) begin
        w_grant_hit = 1'b1;
        w_grant_idx = w_scan;
      end
    end
  end

  assign w_can_issue = (!r_disp_valid || disp_ready) && (r_cnt < c_CNT_W'(MAX_OUTST));
  assign w_push      = w_grant_hit && w_can_issue;
  assign w_rr_next   = (w_grant_idx == c_LANE_W'(NUM_REQS-1)) ? '0 : w_grant_idx + 1'b1;

  always_comb begin
    req_ready = '0;
    if (w_push) req_ready[w_grant_idx] = 1'b1;
  end

  // Commit steering is purely combinational through the head tag.
  assign w_nonempty = (r_cnt != '0);
  assign w_head     = r_fifo[r_rd_ptr];

  always_comb begin
    cmt_out_valid = '0;
    if (cmt_in_valid && w_nonempty) cmt_out_valid[w_head] = 1'b1;
  end

  assign cmt_in_ready = cmt_out_ready[w_head] && w_nonempty;
  assign cmt_out_data = cmt_in_data;
  assign cmt_out_eop  = cmt_in_eop;
  assign w_pop        = cmt_in_valid && cmt_in_ready && cmt_in_eop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
      r_rr_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_orphan_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_disp_valid <= 1'b1;
        r_disp_data  <= w_req_data[w_grant_idx];
        r_rr_ptr     <= w_rr_next;
        r_wr_ptr     <= r_wr_ptr + 1'b1;
      end else if (disp_ready) begin
        r_disp_valid <= 1'b0;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (cmt_in_valid && !w_nonempty) r_orphan_err <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_grant_idx;
  end

  assign disp_valid = r_disp_valid;
  assign disp_data  = r_disp_data;
  assign outst_cnt  = r_cnt;
  assign orphan_err = r_orphan_err;

endmodule
`default_nettype wire

// File: tb/tb_tensor_issue_arbiter.sv
`default_nettype none
// Directed testbench for tensor_issue_arbiter (4 lanes, 4 outstanding).
module tb_tensor_issue_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [255:0] req_data;
  logic [3:0]   req_ready;
  logic         disp_valid;
  logic [63:0]  disp_data;
  logic         disp_ready;
  logic         cmt_in_valid;
  logic [63:0]  cmt_in_data;
  logic         cmt_in_eop;
  logic         cmt_in_ready;
  logic [3:0]   cmt_out_valid;
  logic [63:0]  cmt_out_data;
  logic         cmt_out_eop;
  logic [3:0]   cmt_out_ready;
  logic [2:0]   outst_cnt;
  logic         orphan_err;

  int n_checks = 0;
  int n_fail   = 0;

  tensor_issue_arbiter #(.NUM_REQS(4), .DATA_W(64), .CDATA_W(64), .MAX_OUTST(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready),
    .cmt_in_valid(cmt_in_valid), .cmt_in_data(cmt_in_data), .cmt_in_eop(cmt_in_eop),
    .cmt_in_ready(cmt_in_ready), .cmt_out_valid(cmt_out_valid), .cmt_out_data(cmt_out_data),
    .cmt_out_eop(cmt_out_eop), .cmt_out_ready(cmt_out_ready),
    .outst_cnt(outst_cnt), .orphan_err(orphan_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pay(input int i);
    return 64'h1111_1111_1111_1111 * 64'(i + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_disp_valid: got %b expected 0", disp_valid); end
    n_checks++; if (disp_data !== 64'h0) begin n_fail++; $display("FAIL rst_disp_data: got %h expected 0", disp_data); end
    n_checks++; if (outst_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_outst_cnt: got %0d expected 0", outst_cnt); end
    n_checks++; if (orphan_err !== 1'b0) begin n_fail++; $display("FAIL rst_orphan: got %b expected 0", orphan_err); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
    n_checks++; if (cmt_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmt_in_ready: got %b expected 0", cmt_in_ready); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    for (int i = 0; i < 8; i++) begin
      req_valid = 4'hF; disp_ready = 1'b1; cmt_out_ready = 4'hF;
      cmt_in_valid = (i >= 1); cmt_in_eop = 1'b1;
      #1;
      exp = 4'b0001 << (i % 4);
      n_checks++; if (req_ready !== exp) begin n_fail++; $display("FAIL fair_req_ready[%0d]: got %b expected %b", i, req_ready, exp); end
      if (i >= 1) begin
        exp = 4'b0001 << ((i - 1) % 4);
        n_checks++; if (disp_valid !== 1'b1) begin n_fail++; $display("FAIL fair_disp_valid[%0d]: got %b expected 1", i, disp_valid); end
        n_checks++; if (disp_data !== pay((i - 1) % 4)) begin n_fail++; $display("FAIL fair_disp_data[%0d]: got %h expected %h", i, disp_data, pay((i - 1) % 4)); end
        n_checks++; if (cmt_out_valid !== exp) begin n_fail++; $display("FAIL fair_cmt_route[%0d]: got %b expected %b", i, cmt_out_valid, exp); end
      end
      tick();
    end
    req_valid = 4'h0; cmt_in_valid = 1'b1;
    #1;
    n_checks++; if (cmt_out_valid !== 4'b1000) begin n_fail++; $display("FAIL fair_last_route: got %b expected 1000", cmt_out_valid); end
    n_checks++; if (disp_data !== pay(3)) begin n_fail++; $display("FAIL fair_last_data: got %h expected %h", disp_data, pay(3)); end
    tick();
    cmt_in_valid = 1'b0;
    #1;
    n_checks++; if (outst_cnt !== 3'd0) begin n_fail++; $display("FAIL fair_drain_cnt: got %0d expected 0", outst_cnt); end
    n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL fair_idle_valid: got %b expected 0", disp_valid); end
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0100; disp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_grant: got %b expected 0100", req_ready); end
    tick();
    for (int c = 0; c < 5; c++) begin
      req_valid = 4'hF; disp_ready = 1'b0;
      #1;
      n_checks++; if (disp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, disp_valid); end
      n_checks++; if (disp_data !== pay(2)) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", c, disp_data, pay(2)); end
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %b expected 0000", c, req_ready); end
      tick();
    end
    req_valid = 4'h0; disp_ready = 1'b1;
    #1;
    n_checks++; if (disp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 1", disp_valid); end
    tick();
    cmt_in_valid = 1'b1; cmt_in_eop = 1'b1;
    #1;
    n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_once: got %b expected 0", disp_valid); end
    n_checks++; if (outst_cnt !== 3'd1) begin n_fail++; $display("FAIL bp_cnt: got %0d expected 1", outst_cnt); end
    n_checks++; if (cmt_out_valid !== 4'b0100) begin n_fail++; $display("FAIL bp_route: got %b expected 0100", cmt_out_valid); end
    tick();
    cmt_in_valid = 1'b0;
    #1;
    n_checks++; if (outst_cnt !== 3'd0) begin n_fail++; $display("FAIL bp_drain: got %0d expected 0", outst_cnt); end
  endtask

  task automatic test_full();
    logic [3:0] exp;
    req_valid = 4'hF; disp_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      exp = 4'b0001 << ((3 + j) % 4);
      n_checks++; if (req_ready !== exp) begin n_fail++; $display("FAIL full_grant[%0d]: got %b expected %b", j, req_ready, exp); end
      tick();
    end
    #1;
    n_checks++; if (outst_cnt !== 3'd4) begin n_fail++; $display("FAIL full_cnt: got %0d expected 4", outst_cnt); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL full_req_ready: got %b expected 0000", req_ready); end
    tick();
    cmt_in_valid = 1'b1; cmt_in_eop = 1'b1;
    #1;
    n_checks++; if (cmt_out_valid !== 4'b1000) begin n_fail++; $display("FAIL full_route: got %b expected 1000", cmt_out_valid); end
    n_checks++; if (cmt_in_ready !== 1'b1) begin n_fail++; $display("FAIL full_cmt_ready: got %b expected 1", cmt_in_ready); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL full_no_bypass: got %b expected 0000", req_ready); end
    tick();
    cmt_in_valid = 1'b0;
    #1;
    n_checks++; if (outst_cnt !== 3'd3) begin n_fail++; $display("FAIL full_pop_cnt: got %0d expected 3", outst_cnt); end
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL full_refill: got %b expected 1000", req_ready); end
    tick();
    req_valid = 4'h0;
    for (int k = 0; k < 4; k++) begin
      cmt_in_valid = 1'b1;
      #1;
      exp = 4'b0001 << k;
      n_checks++; if (cmt_out_valid !== exp) begin n_fail++; $display("FAIL full_drain_route[%0d]: got %b expected %b", k, cmt_out_valid, exp); end
      tick();
    end
    cmt_in_valid = 1'b0;
    #1;
    n_checks++; if (outst_cnt !== 3'd0) begin n_fail++; $display("FAIL full_drain_cnt: got %0d expected 0", outst_cnt); end
  endtask

  task automatic test_commit_routing();
    req_valid = 4'b1000;
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL cr_grant3: got %b expected 1000", req_ready); end
    tick();
    req_valid = 4'b0010;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL cr_grant1: got %b expected 0010", req_ready); end
    tick();
    req_valid = 4'h0; cmt_in_valid = 1'b1; cmt_in_eop = 1'b0; cmt_in_data = 64'hDEAD_BEEF_0000_AAAA;
    #1;
    n_checks++; if (cmt_out_valid !== 4'b1000) begin n_fail++; $display("FAIL cr_beat0: got %b expected 1000", cmt_out_valid); end
    n_checks++; if (cmt_out_data !== 64'hDEAD_BEEF_0000_AAAA) begin n_fail++; $display("FAIL cr_data: got %h expected deadbeef0000aaaa", cmt_out_data); end
    n_checks++; if (cmt_out_eop !== 1'b0) begin n_fail++; $display("FAIL cr_eop0: got %b expected 0", cmt_out_eop); end
    tick();
    cmt_in_eop = 1'b1;
    #1;
    n_checks++; if (outst_cnt !== 3'd2) begin n_fail++; $display("FAIL cr_nopop: got %0d expected 2", outst_cnt); end
    n_checks++; if (cmt_out_valid !== 4'b1000) begin n_fail++; $display("FAIL cr_beat1: got %b expected 1000", cmt_out_valid); end
    tick();
    #1;
    n_checks++; if (cmt_out_valid !== 4'b0010) begin n_fail++; $display("FAIL cr_beat2: got %b expected 0010", cmt_out_valid); end
    tick();
    cmt_in_valid = 1'b0;
    #1;
    n_checks++; if (outst_cnt !== 3'd0) begin n_fail++; $display("FAIL cr_empty: got %0d expected 0", outst_cnt); end
  endtask

  task automatic test_commit_stall_simul();
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL cs_grant0: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'h0; cmt_in_valid = 1'b1; cmt_in_eop = 1'b1; cmt_out_ready = 4'b1110;
    #1;
    n_checks++; if (cmt_in_ready !== 1'b0) begin n_fail++; $display("FAIL cs_stall_ready: got %b expected 0", cmt_in_ready); end
    n_checks++; if (cmt_out_valid !== 4'b0001) begin n_fail++; $display("FAIL cs_stall_route: got %b expected 0001", cmt_out_valid); end
    tick();
    cmt_out_ready = 4'hF; req_valid = 4'b0010;
    #1;
    n_checks++; if (outst_cnt !== 3'd1) begin n_fail++; $display("FAIL cs_stall_cnt: got %0d expected 1", outst_cnt); end
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL cs_simul_grant: got %b expected 0010", req_ready); end
    n_checks++; if (cmt_in_ready !== 1'b1) begin n_fail++; $display("FAIL cs_simul_ready: got %b expected 1", cmt_in_ready); end
    tick();
    req_valid = 4'h0;
    #1;
    n_checks++; if (outst_cnt !== 3'd1) begin n_fail++; $display("FAIL cs_simul_cnt: got %0d expected 1", outst_cnt); end
    n_checks++; if (cmt_out_valid !== 4'b0010) begin n_fail++; $display("FAIL cs_next_head: got %b expected 0010", cmt_out_valid); end
    tick();
    cmt_in_valid = 1'b0;
    #1;
    n_checks++; if (outst_cnt !== 3'd0) begin n_fail++; $display("FAIL cs_drain: got %0d expected 0", outst_cnt); end
  endtask

  task automatic test_error_reset();
    cmt_in_valid = 1'b1; cmt_in_eop = 1'b1;
    #1;
    n_checks++; if (cmt_in_ready !== 1'b0) begin n_fail++; $display("FAIL er_ready: got %b expected 0", cmt_in_ready); end
    n_checks++; if (cmt_out_valid !== 4'b0000) begin n_fail++; $display("FAIL er_route: got %b expected 0000", cmt_out_valid); end
    tick();
    cmt_in_valid = 1'b0;
    #1;
    n_checks++; if (orphan_err !== 1'b1) begin n_fail++; $display("FAIL er_set: got %b expected 1", orphan_err); end
    tick();
    req_valid = 4'hF;
    #1;
    n_checks++; if (orphan_err !== 1'b1) begin n_fail++; $display("FAIL er_sticky: got %b expected 1", orphan_err); end
    tick();
    #1;
    n_checks++; if (disp_data !== pay(2)) begin n_fail++; $display("FAIL er_pre_data: got %h expected %h", disp_data, pay(2)); end
    #2;
    reset = 1'b0; req_valid = 4'h0;
    #1;
    n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b expected 0", disp_valid); end
    n_checks++; if (disp_data !== 64'h0) begin n_fail++; $display("FAIL ar_data: got %h expected 0", disp_data); end
    n_checks++; if (outst_cnt !== 3'd0) begin n_fail++; $display("FAIL ar_cnt: got %0d expected 0", outst_cnt); end
    n_checks++; if (orphan_err !== 1'b0) begin n_fail++; $display("FAIL ar_orphan: got %b expected 0", orphan_err); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL ar_req_ready: got %b expected 0000", req_ready); end
    tick();
    reset = 1'b1; req_valid = 4'hF;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL ar_first_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'h0;
    #1;
    n_checks++; if (disp_data !== pay(0)) begin n_fail++; $display("FAIL ar_first_data: got %h expected %h", disp_data, pay(0)); end
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; disp_ready = 1'b1;
    cmt_in_valid = 1'b0; cmt_in_data = '0; cmt_in_eop = 1'b0; cmt_out_ready = 4'hF;
    for (int i = 0; i < 4; i++) req_data[i*64 +: 64] = pay(i);
    tick();
    test_reset();
    test_fairness();
    test_backpressure();
    test_full();
    test_commit_routing();
    test_commit_stall_simul();
    test_error_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
